// File: rtl/down_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : down_timer_pkg
// Brief   : Shared width default and FSM state encoding for down_timer.
// Revision: 1.0 - initial release
// ============================================================================
package down_timer_pkg;

   localparam int DEFAULT_BITS = 8;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

endpackage : down_timer_pkg
`default_nettype wire

// File: rtl/down_timer_if.sv
`default_nettype none
// ============================================================================
// Module  : down_timer_if
// Brief   : Control and status bundle between a host and down_timer.
// Revision: 1.0 - initial release
// ============================================================================
interface down_timer_if #(
   parameter int bits = 8
);
   logic            load;
   logic [bits-1:0] load_val;
   logic            start;
   logic            pause;
   logic            reload_en;
   logic [bits-1:0] q;
   logic            empty;
   logic            done;
   logic            busy;

   modport master (
      output load, load_val, start, pause, reload_en,
      input  q, empty, done, busy
   );

   modport slave (
      input  load, load_val, start, pause, reload_en,
      output q, empty, done, busy
   );
endinterface : down_timer_if
`default_nettype wire

// File: rtl/down_timer.sv
`default_nettype none
// ============================================================================
// Module  : down_timer
// Brief   : Loadable down counter with pause/resume, one-shot or auto-reload.
// Revision: 1.0 - initial release
// ============================================================================
module down_timer
   import down_timer_pkg::*;
#(
   parameter int bits = DEFAULT_BITS
) (
   input  wire logic   clk,
   input  wire logic   reset,
   down_timer_if.slave tif
);

   localparam logic [bits-1:0] c_zero = '0;
   localparam logic [bits-1:0] c_one  = {{(bits-1){1'b0}}, 1'b1};

   state_t          r_state;
   logic [bits-1:0] r_q;
   logic [bits-1:0] r_reload;
   logic            r_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_q      <= c_zero;
         r_reload <= c_zero;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (tif.load) begin
            r_q      <= tif.load_val;
            r_reload <= tif.load_val;
            r_state  <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  // pause outranks start, so it blocks a start even in IDLE
                  if (tif.start && !tif.pause) begin
                     if (r_q != c_zero) begin
                        r_state <= ST_RUN;
                     end else begin
                        r_done <= 1'b1;
                     end
                  end
               end
               ST_RUN: begin
                  if (tif.pause) begin
                     r_state <= ST_HOLD;
                  end else if (r_q == c_one) begin
                     r_done <= 1'b1;
                     if (tif.reload_en && (r_reload != c_zero)) begin
                        r_q <= r_reload;
                     end else begin
                        r_q     <= c_zero;
                        r_state <= ST_IDLE;
                     end
                  end else if (r_q == c_zero) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_q <= r_q - c_one;
                  end
               end
               ST_HOLD: begin
                  if (tif.start && !tif.pause) begin
                     r_state <= ST_RUN;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign tif.q     = r_q;
   assign tif.empty = (r_q == c_zero);
   assign tif.done  = r_done;
   assign tif.busy  = (r_state != ST_IDLE);

endmodule : down_timer
`default_nettype wire
